// File: rtl/systolic_pkg.sv
// systolic_pkg: shared sizes, feeder FSM states and tile-select codes for the systolic array feeder
package systolic_pkg;
  localparam int DATA_W = 8;
  localparam int N = 4;
  localparam int K = 4;
  localparam int FLUSH_CYCLES = 12;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} feeder_state_t;
  localparam logic TILE_SEL_A = 1'b0;
  localparam logic TILE_SEL_W = 1'b1;
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: tile write port, start strobe and the array-facing lanes/controls of the feeder
interface systolic_feeder_if #(parameter int DATA_W = systolic_pkg::DATA_W);
  logic wr_en;
  logic wr_sel;
  logic [1:0] wr_row;
  logic [1:0] wr_col;
  logic [DATA_W-1:0] wr_data;
  logic start;
  logic [DATA_W-1:0] a0, a4, a8, a12;
  logic [DATA_W-1:0] w0, w1, w2, w3;
  logic WEn, pauseProcess, busy, done, wr_err;
  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input a0, a4, a8, a12, w0, w1, w2, w3, WEn, pauseProcess, busy, done, wr_err
  );
  modport slave (
    input wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a0, a4, a8, a12, w0, w1, w2, w3, WEn, pauseProcess, busy, done, wr_err
  );
endinterface

// File: rtl/feeder_tile_buf.sv
// feeder_tile_buf: NxK element store, one write port and one combinational read port per lane
module feeder_tile_buf #(
  parameter int DATA_W = 8,
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [$clog2(N)-1:0] wr_lane,
  input  logic [$clog2(K)-1:0] wr_k,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [$clog2(K)-1:0] rd_k [N],
  output logic [DATA_W-1:0] rd_data [N]
);
  logic [DATA_W-1:0] mem [N][K];
  always_ff @(posedge clk)
    if (rst) mem <= '{default: '0};
    else if (wr_en) mem[wr_lane][wr_k] <= wr_data;
  always_comb
    for (int i = 0; i < N; i++) rd_data[i] = mem[i][rd_k[i]];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: streams A/W tiles diagonally skewed onto the array lanes, then flushes and pulses done.
// FEEDER_DOUBLE_BUF_EN selects ping-pong tile banks with back-to-back starts.
module systolic_feeder #(
  parameter int DATA_W = systolic_pkg::DATA_W,
  parameter int N = systolic_pkg::N,
  parameter int K = systolic_pkg::K,
  parameter int FLUSH_CYCLES = systolic_pkg::FLUSH_CYCLES
) (
  input logic clk,
  input logic rst,
  systolic_feeder_if.slave f
);
  import systolic_pkg::*;
  localparam int KW = $clog2(K);
  localparam int CW = $clog2(FLUSH_CYCLES + K + N);
`ifdef FEEDER_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  feeder_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic start_ok, wr_ok, bank, wbank;
  logic [KW-1:0] rd_k [N];
  logic [N-1:0] lane_ok;
  logic [DATA_W-1:0] a_rd [NB][N];
  logic [DATA_W-1:0] w_rd [NB][N];
  logic [DATA_W-1:0] a_q [N];
  logic [DATA_W-1:0] w_q [N];
`ifdef FEEDER_DOUBLE_BUF_EN
  // writes always land in the shadow bank; start flips which bank streams
  assign start_ok = f.start && (state == IDLE || state == DONE);
  assign wr_ok = f.wr_en;
  assign wbank = ~bank;
  assign f.wr_err = 1'b0;
  always_ff @(posedge clk) bank <= rst ? 1'b0 : bank ^ start_ok;
`else
  assign start_ok = f.start && state == IDLE;
  assign wr_ok = f.wr_en && state == IDLE;
  assign bank = 1'b0;
  assign wbank = 1'b0;
  always_ff @(posedge clk) f.wr_err <= rst ? 1'b0 : f.wr_en && state != IDLE;
`endif
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
    cnt <= (rst || state != state_nxt) ? '0 : cnt + CW'(1);
  end
  always_comb
    state_nxt = (state == IDLE)  ? (start_ok ? FEED : IDLE) :
                (state == FEED)  ? ((cnt == CW'(K + N - 2)) ? FLUSH : FEED) :
                (state == FLUSH) ? ((cnt == CW'(FLUSH_CYCLES - 1)) ? DONE : FLUSH) :
                (start_ok ? FEED : IDLE);
  always_comb begin
    f.busy = state == FEED || state == FLUSH;
    f.WEn = state == FEED || state == FLUSH;
    f.pauseProcess = state == FEED || state == FLUSH;
    f.done = state == DONE;
  end
  // lane i carries element k = t - i; A and W share the same skew so one index set serves both
  always_comb
    for (int i = 0; i < N; i++) begin
      lane_ok[i] = state == FEED && int'(cnt) >= i && int'(cnt) - i < K;
      rd_k[i] = KW'(int'(cnt) - i);
    end
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic we_a, we_w;
    assign we_a = wr_ok && f.wr_sel == TILE_SEL_A && wbank == 1'(b);
    assign we_w = wr_ok && f.wr_sel == TILE_SEL_W && wbank == 1'(b);
    feeder_tile_buf #(.DATA_W(DATA_W), .N(N), .K(K)) u_a (
      .clk(clk), .rst(rst), .wr_en(we_a), .wr_lane(f.wr_row), .wr_k(f.wr_col),
      .wr_data(f.wr_data), .rd_k(rd_k), .rd_data(a_rd[b])
    );
    feeder_tile_buf #(.DATA_W(DATA_W), .N(N), .K(K)) u_w (
      .clk(clk), .rst(rst), .wr_en(we_w), .wr_lane(f.wr_col), .wr_k(f.wr_row),
      .wr_data(f.wr_data), .rd_k(rd_k), .rd_data(w_rd[b])
    );
  end
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++) begin
      a_q[i] <= (rst || !lane_ok[i]) ? '0 : a_rd[bank][i];
      w_q[i] <= (rst || !lane_ok[i]) ? '0 : w_rd[bank][i];
    end
  assign f.a0 = a_q[0];
  assign f.a4 = a_q[1];
  assign f.a8 = a_q[2];
  assign f.a12 = a_q[3];
  assign f.w0 = w_q[0];
  assign f.w1 = w_q[1];
  assign f.w2 = w_q[2];
  assign f.w3 = w_q[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed checks of skewed streaming, FSM timing, reset, dropped writes and (FEEDER_DOUBLE_BUF_EN) back-to-back tiles
module tb_systolic_feeder;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  logic [7:0] ma [4][4];
  logic [7:0] mw [4][4];
  logic [63:0] cap [21];
  systolic_feeder_if #(.DATA_W(8)) f ();
  systolic_feeder dut (.clk(clk), .rst(rst), .f(f));
  always #5 clk = ~clk;

  function automatic logic [63:0] lanes();
    return {f.a0, f.a4, f.a8, f.a12, f.w0, f.w1, f.w2, f.w3};
  endfunction

  function automatic logic [4:0] status();
    return {f.busy, f.WEn, f.pauseProcess, f.done, f.wr_err};
  endfunction

  function automatic logic [63:0] exp_lanes(input int t);
    logic [63:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) begin
        r[63-8*i -: 8] = ma[i][t-i];
        r[31-8*i -: 8] = mw[t-i][i];
      end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input int r, input int c, input logic [7:0] d, input bit upd);
    f.wr_en = 1'b1;
    f.wr_sel = sel;
    f.wr_row = 2'(r);
    f.wr_col = 2'(c);
    f.wr_data = d;
    if (upd && !sel) ma[r][c] = d;
    if (upd && sel) mw[r][c] = d;
    tick();
    f.wr_en = 1'b0;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 8'h00;
        mw[i][k] = 8'h00;
      end
  endtask

  task automatic load_tiles();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) wr(1'b0, i, k, 8'(4 * i + k + 1), 1'b1);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) wr(1'b1, k, j, 8'(16 + 4 * k + j), 1'b1);
  endtask

  // sample c is taken 1 time unit after the c-th edge following the start edge
  task automatic run_stream(input int flush_start);
    logic [4:0] es;
    logic [63:0] el;
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    f.wr_en = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      f.start = (c == flush_start);
      es = {c < 19, c < 19, c < 19, c == 19, 1'b0};
      el = (c >= 1 && c <= 7) ? exp_lanes(c - 1) : 64'h0;
      cap[c] = lanes();
      checks++;
      if (status() !== es) begin
        fails++;
        $display("FAIL stream_status c=%0d: got %b want %b", c, status(), es);
      end
      checks++;
      if (cap[c] !== el) begin
        fails++;
        $display("FAIL stream_lanes c=%0d: got %h want %h", c, cap[c], el);
      end
    end
    f.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({lanes(), status()} !== 69'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {lanes(), status()});
    end
  endtask

  task automatic test_stream();
    load_tiles();
    run_stream(-1);
    checks++;
    if ({cap[1][63:56], cap[1][31:24]} !== 16'h0110) begin
      fails++;
      $display("FAIL cycle0_a0_w0: got %h want 0110", {cap[1][63:56], cap[1][31:24]});
    end
    checks++;
    if ({cap[4][39:32], cap[4][7:0]} !== {8'd13, 8'd19}) begin
      fails++;
      $display("FAIL cycle3_a12_w3: got %h want %h", {cap[4][39:32], cap[4][7:0]}, {8'd13, 8'd19});
    end
    checks++;
    if ({cap[7][63:40], cap[7][39:32], cap[7][31:8], cap[7][7:0]} !== {24'h0, 8'd16, 24'h0, 8'd31}) begin
      fails++;
      $display("FAIL cycle6_lanes: got %h want %h", cap[7], {24'h0, 8'd16, 24'h0, 8'd31});
    end
  endtask

  task automatic test_write_with_start();
    load_tiles();
    f.wr_en = 1'b1;
    f.wr_sel = 1'b0;
    f.wr_row = 2'd1;
    f.wr_col = 2'd0;
    f.wr_data = 8'h77;
    ma[1][0] = 8'h77;
    run_stream(-1);
    checks++;
    if (cap[2][55:48] !== 8'h77) begin
      fails++;
      $display("FAIL write_with_start_a4: got %h want 77", cap[2][55:48]);
    end
  endtask

  task automatic test_flush_start();
    load_tiles();
    run_stream(10);
  endtask

  task automatic test_reset_mid();
    bit seen_done = 1'b0;
    load_tiles();
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({lanes(), status()} !== 69'h0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h want 0", {lanes(), status()});
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (f.done) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %b want 0", seen_done);
    end
    clr_model();
    run_stream(-1);
    load_tiles();
    run_stream(-1);
  endtask

`ifdef FEEDER_DOUBLE_BUF_EN
  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_tiles();
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    clr_model();
    for (int c = 0; c < 19; c++)
      if (c < 16) wr(1'b0, c / 4, c % 4, 8'(128 + c), 1'b1);
      else wr(1'b1, 0, c - 16, 8'(160 + c), 1'b1);
    checks++;
    if (f.done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done: got %b want 1", f.done);
    end
    run_stream(-1);
    checks++;
    if (cap[1][63:56] !== 8'h80) begin
      fails++;
      $display("FAIL b2b_a0: got %h want 80", cap[1][63:56]);
    end
  endtask
`else
  task automatic test_wr_err();
    load_tiles();
    f.start = 1'b1;
    tick();
    f.start = 1'b0;
    tick();
    tick();
    wr(1'b0, 0, 0, 8'h55, 1'b0);
    checks++;
    if (f.wr_err !== 1'b1) begin
      fails++;
      $display("FAIL wr_err_pulse: got %b want 1", f.wr_err);
    end
    tick();
    checks++;
    if (f.wr_err !== 1'b0) begin
      fails++;
      $display("FAIL wr_err_clear: got %b want 0", f.wr_err);
    end
    for (int c = 4; c < 20; c++) tick();
    checks++;
    if (f.busy !== 1'b0) begin
      fails++;
      $display("FAIL wr_err_idle: got %b want 0", f.busy);
    end
    run_stream(-1);
    checks++;
    if (cap[1][63:56] !== 8'h01) begin
      fails++;
      $display("FAIL wr_err_replay_a0: got %h want 01", cap[1][63:56]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    f.wr_en = 1'b0;
    f.wr_sel = 1'b0;
    f.wr_row = 2'd0;
    f.wr_col = 2'd0;
    f.wr_data = 8'h00;
    f.start = 1'b0;
    clr_model();
    test_reset();
    test_stream();
    test_write_with_start();
    test_flush_start();
    test_reset_mid();
`ifdef FEEDER_DOUBLE_BUF_EN
    test_back_to_back();
`else
    test_wr_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
